// File: rtl/formula_sweep_pkg.sv
// Shared types and sizing helpers for the formula sweep driver.
package formula_sweep_pkg;

  localparam int unsigned N_IN_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sweep_state_t;

  // One extra bit so the counter can hold 2^n when every assignment satisfies.
  function automatic int unsigned cnt_w(input int unsigned n);
    return n + 1;
  endfunction

endpackage

// File: rtl/formula_sweep_driver_witness_slot.sv
// Single-entry valid/ready holding register for satisfying assignments.
module witness_slot #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         wit_ready,
  output logic         wit_valid,
  output logic [W-1:0] wit_data,
  output logic         slot_free
);

  // Free when empty or when the held entry leaves on this edge.
  assign slot_free = !wit_valid || wit_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wit_valid <= 1'b0;
      wit_data  <= '0;
    end else if (load) begin
      wit_valid <= 1'b1;
      wit_data  <= load_data;
    end else if (wit_valid && wit_ready) begin
      wit_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/formula_sweep_driver.sv
// Sweeps all formula input assignments, counts satisfying ones and streams witnesses.
module formula_sweep_driver
  import formula_sweep_pkg::*;
#(
  parameter int unsigned N_IN  = N_IN_DEFAULT,
  parameter int unsigned CNT_W = cnt_w(N_IN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop_first,
  output logic [N_IN-1:0]  formula_in,
  input  logic             formula_out,
  output logic             wit_valid,
  input  logic             wit_ready,
  output logic [N_IN-1:0]  wit_data,
  output logic [CNT_W-1:0] sat_count,
  output logic             busy,
  output logic             done
);

  sweep_state_t state;
  logic         stop_first_q;
  logic         slot_free;
  logic         load;
  logic         stall;
  logic         last_assign;

  assign load        = (state == SWEEP) && formula_out && slot_free;
  assign stall       = formula_out && !slot_free;
  assign last_assign = (formula_in == '1);

  witness_slot #(
    .W (N_IN)
  ) u_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (formula_in),
    .wit_ready (wit_ready),
    .wit_valid (wit_valid),
    .wit_data  (wit_data),
    .slot_free (slot_free)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      formula_in   <= '0;
      sat_count    <= '0;
      stop_first_q <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            formula_in   <= '0;
            sat_count    <= '0;
            stop_first_q <= stop_first;
            busy         <= 1'b1;
            state        <= SWEEP;
          end
        end
        SWEEP: begin
          if (!stall) begin
            if (formula_out) begin
              sat_count <= sat_count + CNT_W'(1);
            end
            // The all-ones test precedes the increment, so the register never wraps.
            if (last_assign || (stop_first_q && formula_out)) begin
              state <= DRAIN;
            end else begin
              formula_in <= formula_in + N_IN'(1);
            end
          end
        end
        DRAIN: begin
          if (slot_free) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_formula_sweep_driver.sv
// Self-checking bench: 16-input benchmark formula and a 4-input always-true formula.
module tb_formula_sweep_driver;

  logic        clk = 1'b0;
  logic        rst, start, stop_first, wit_ready, formula_out;
  logic        wit_valid, busy, done;
  logic [15:0] formula_in, wit_data;
  logic [16:0] sat_count;

  logic        start4, ready4, wit_valid4, busy4, done4;
  logic [3:0]  formula_in4, wit_data4;
  logic [4:0]  sat_count4;

  int unsigned tests  = 0;
  int unsigned failed = 0;

  int unsigned prefix [0:65536];
  logic [15:0] sat_list [$];
  logic [15:0] got [$];

  always #5 clk = ~clk;

  function automatic logic formula(input logic [15:0] x);
    return (^x) & (~x[0] | x[15]) & (~x[1] | x[14]) & (~x[2] | x[13]) & (~x[3] | x[12]);
  endfunction

  assign formula_out = formula(formula_in);

  formula_sweep_driver #(
    .N_IN  (16),
    .CNT_W (17)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop_first  (stop_first),
    .formula_in  (formula_in),
    .formula_out (formula_out),
    .wit_valid   (wit_valid),
    .wit_ready   (wit_ready),
    .wit_data    (wit_data),
    .sat_count   (sat_count),
    .busy        (busy),
    .done        (done)
  );

  formula_sweep_driver #(
    .N_IN  (4),
    .CNT_W (5)
  ) dut4 (
    .clk         (clk),
    .rst         (rst),
    .start       (start4),
    .stop_first  (1'b0),
    .formula_in  (formula_in4),
    .formula_out (1'b1),
    .wit_valid   (wit_valid4),
    .wit_ready   (ready4),
    .wit_data    (wit_data4),
    .sat_count   (sat_count4),
    .busy        (busy4),
    .done        (done4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_formula_in"}, formula_in, 0);
    check({pfx, "_wit_valid"},  wit_valid,  0);
    check({pfx, "_wit_data"},   wit_data,   0);
    check({pfx, "_sat_count"},  sat_count,  0);
    check({pfx, "_busy"},       busy,       0);
    check({pfx, "_done"},       done,       0);
  endtask

  // Runs one sweep on the 16-input instance; bp_len cycles of back-pressure after
  // the first witness appears; kick_cyc != 0 pulses start mid-sweep.
  task automatic sweep16(input bit sf, input int unsigned bp_len, input int unsigned kick_cyc,
                         output int unsigned done_cyc, output int unsigned done_cnt,
                         output int unsigned t_first);
    int unsigned bp_left = 0;
    bit          seen_wv = 1'b0;
    got.delete();
    done_cyc = 0;
    done_cnt = 0;
    t_first  = 0;
    @(negedge clk);
    stop_first = sf;
    wit_ready  = 1'b1;
    start      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start      = 1'b0;
    stop_first = ~sf;
    check("sweep_begins_at_zero", formula_in, 0);
    for (int unsigned cyc = 0; cyc < 70000; cyc++) begin
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) done_cyc = cyc;
      end
      if (formula_in == sat_list[0] && t_first == 0) t_first = cyc;
      if (wit_valid && !seen_wv) begin
        seen_wv = 1'b1;
        bp_left = bp_len;
      end
      if (bp_left > 0) begin
        wit_ready = 1'b0;
        bp_left--;
      end else begin
        wit_ready = 1'b1;
      end
      start = (kick_cyc != 0 && cyc == kick_cyc);
      if (kick_cyc != 0 && cyc == kick_cyc + 1) begin
        check("busy_start_keeps_busy", busy, 1);
        check("busy_start_count_kept", sat_count, prefix[formula_in]);
      end
      if (bp_len != 0 && cyc == sat_list[0] + bp_len) begin
        check("stall_holds_next_hit", formula_in, sat_list[1]);
        check("stall_count", sat_count, 1);
      end
      if (wit_valid && wit_ready) got.push_back(wit_data);
      if (done_cnt > 0 && cyc >= done_cyc + 4) break;
      @(posedge clk);
      @(negedge clk);
    end
    start     = 1'b0;
    wit_ready = 1'b1;
  endtask

  task automatic sweep4(input bit rnd, output int unsigned done_cyc, output int unsigned done_cnt);
    got.delete();
    done_cyc = 0;
    done_cnt = 0;
    @(negedge clk);
    ready4 = 1'b1;
    start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    for (int unsigned cyc = 0; cyc < 300; cyc++) begin
      if (done4) begin
        done_cnt++;
        if (done_cnt == 1) done_cyc = cyc;
      end
      ready4 = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (wit_valid4 && ready4) got.push_back({12'h000, wit_data4});
      if (done_cnt > 0 && cyc >= done_cyc + 4) break;
      @(posedge clk);
      @(negedge clk);
    end
    ready4 = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned done_cyc, done_cnt, t_first, stall, mism, rst_cyc, kick;
    logic [15:0] a;

    prefix[0] = 0;
    for (int v = 0; v < 65536; v++) begin
      a = v[15:0];
      prefix[v+1] = prefix[v] + (formula(a) ? 1 : 0);
      if (formula(a)) sat_list.push_back(a);
    end

    rst = 1'b1; start = 1'b0; stop_first = 1'b0; wit_ready = 1'b1;
    start4 = 1'b0; ready4 = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("reset");
    check("reset_sat_count4", sat_count4, 0);
    check("reset_wit_valid4", wit_valid4, 0);
    rst = 1'b0;
    @(negedge clk);
    check_zero("post_reset");

    // stop at first witness
    sweep16(1'b1, 0, 0, done_cyc, done_cnt, t_first);
    check("sf_witness_count", got.size(), 1);
    check("sf_witness_value", (got.size() > 0) ? got[0] : 16'hxxxx, sat_list[0]);
    check("sf_formula_in_final", formula_in, sat_list[0]);
    check("sf_sat_count", sat_count, 1);
    check("sf_done_pulses", done_cnt, 1);
    check("sf_done_latency", done_cyc, t_first + 2);
    check("sf_busy_after", busy, 0);

    // asynchronous reset mid-sweep with a witness pending
    rst_cyc = $urandom_range(40, 400);
    @(negedge clk);
    stop_first = 1'b0;
    wit_ready  = 1'b0;
    start      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (rst_cyc) @(negedge clk);
    check("pre_reset_wit_valid", wit_valid, 1);
    check("pre_reset_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check_zero("async_reset");
    @(negedge clk);
    rst       = 1'b0;
    wit_ready = 1'b1;

    // full sweep after reset, back-pressure and an ignored start pulse
    kick = $urandom_range(100, 60000);
    sweep16(1'b0, 20, kick, done_cyc, done_cnt, t_first);
    stall = sat_list[0] + 1 + 20 - sat_list[1];
    check("full_done_cycle", done_cyc, 65536 + 1 + stall);
    check("full_done_pulses", done_cnt, 1);
    check("full_sat_count", sat_count, sat_list.size());
    check("full_sat_count_10368", sat_count, 10368);
    check("full_witness_count", got.size(), sat_list.size());
    mism = 0;
    foreach (sat_list[i]) if (i >= got.size() || got[i] !== sat_list[i]) mism++;
    check("full_witness_order", mism, 0);
    check("full_first_witness", (got.size() > 0) ? got[0] : 16'hxxxx, 16'h0010);
    check("full_formula_in_final", formula_in, 16'hFFFF);
    check("full_busy_after", busy, 0);
    check("full_wit_valid_after", wit_valid, 0);

    // 4-input always-true formula, clean then random back-pressure
    for (int r = 0; r < 2; r++) begin
      sweep4(r == 1, done_cyc, done_cnt);
      check("n4_witness_count", got.size(), 16);
      mism = 0;
      foreach (got[i]) if (got[i] !== 16'(i)) mism++;
      check("n4_witness_order", mism, 0);
      check("n4_sat_count", sat_count4, 16);
      check("n4_formula_in_final", formula_in4, 4'hF);
      check("n4_done_pulses", done_cnt, 1);
      if (r == 0) check("n4_done_cycle", done_cyc, 17);
      check("n4_busy_after", busy4, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/formula_sweep_driver.md
# formula_sweep_driver

Sequential stimulus stage sitting directly upstream of a combinational benchmark formula (16 inputs, single `out`). It sweeps every input assignment in ascending binary order and drives `formula_in`. It samples the formula's `out` in the same cycle, counts satisfying assignments, and streams each witness over a valid/ready channel. This turns any combinational `formula` benchmark into a checkable model counter and witness enumerator.

## Interface
- `N_IN`, 16, number of formula inputs; `formula_in[k]` drives formula input `i_k`.
- `CNT_W`, `N_IN+1`, width of the satisfying-assignment counter; must hold the value 2^N_IN.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: a one-cycle pulse in IDLE or DONE begins a sweep; ignored while `busy`.
- `stop_first` in 1: sampled at `start`. When 1, the sweep ends after the first witness is accepted.
- `formula_in` out N_IN: current assignment, fed to the formula.
- `formula_out` in 1: the formula result for the current `formula_in`, combinational.
- `wit_valid` out 1: a witness is held on `wit_data`.
- `wit_ready` in 1: downstream accepts the witness when `wit_valid && wit_ready`.
- `wit_data` out N_IN: the satisfying assignment.
- `sat_count` out CNT_W: number of satisfying assignments found in the current or last sweep.
- `busy` out 1: high in SWEEP and DRAIN.
- `done` out 1: one-cycle pulse on entry to DONE.

## Operation
- States:
  - IDLE (reset state)
  - SWEEP
  - DRAIN
  - DONE
- IDLE/DONE + `start`:
  - `formula_in` <= 0, `sat_count` <= 0, latch `stop_first`, go to SWEEP.
  - A witness still pending from the previous sweep is kept until accepted.
- SWEEP, each cycle, with `hit = formula_out`:
  - `hit` and witness slot busy (`wit_valid && !wit_ready`): stall. Hold `formula_in`; counter unchanged.
  - `hit` and slot free or being freed this cycle: load `wit_data` <= `formula_in`, set `wit_valid`, increment `sat_count`, advance.
  - `!hit`: advance, no other effect.
- Advance rule:
  - If `formula_in` == all-ones, or (`stop_first` and this cycle was a hit): go to DRAIN.
  - Otherwise `formula_in` <= `formula_in` + 1.
- DRAIN:
  - Wait until `wit_valid` is 0, or is being accepted this cycle, then go to DONE.
  - `formula_in` holds its final value.
- DONE:
  - `done` high for exactly the entry cycle.
  - `sat_count` and `formula_in` hold until the next `start`.
- Witness slot: one entry.
  - Cleared on acceptance, unless reloaded in the same cycle, in which case `wit_valid` stays 1 with the new data.
- Counter arithmetic:
  - Unsigned, CNT_W bits, never saturates; the maximum reachable value is 2^N_IN.
  - The assignment register is N_IN bits; wrap-around is never executed because the all-ones check precedes the increment.
- `rst` asserted at any time, including mid-sweep with a witness pending:
  - Immediately forces IDLE, `formula_in`=0, `wit_valid`=0, `wit_data`=0, `sat_count`=0, `busy`=0, `done`=0.
  - A partially swept run is discarded.

## Timing
- Reset values: all outputs 0.
- Throughput: one assignment per cycle when no stall occurs; a full unstalled sweep takes 2^N_IN SWEEP cycles.
- Witness latency: the assignment is presented in cycle t; `wit_valid`/`wit_data` update at the edge ending cycle t.
- `formula_out` is sampled in the same cycle as `formula_in`; the formula must be purely combinational and fit within one clock period.
- `done` occurs ≥1 cycle after the last assignment, and only once no witness is pending.

## Structure
- Package `formula_sweep_pkg`:
  - state enum `sweep_state_t` (IDLE, SWEEP, DRAIN, DONE)
  - default `N_IN` localparam
  - helper function `cnt_w(n)`
- Sub-module `witness_slot`:
  - single-entry valid/ready register with load/accept-same-cycle handling
  - drives `wit_valid`/`wit_data`
- The top level instantiates `witness_slot`, the FSM and the counters; the DUT formula is instantiated only in the testbench.

## Test plan
- Full sweep, `stop_first`=0, `wit_ready`=1, formula = 16-input XOR of all inputs AND implications i_0→i_15, i_1→i_14, i_2→i_13, i_3→i_12 -> `sat_count`=10368 at `done`. The first witness is 0x0010, 10368 witnesses are streamed, and `done` occurs after 65536 sweep cycles plus 1.
- `stop_first`=1, same formula -> exactly one witness, 0x0010. `formula_in` stops at 0x0010, `sat_count`=1, `done` asserts 2 cycles after 0x0010 is presented.
- Back-pressure: `wit_ready` low for 20 cycles after the first witness -> `formula_in` stalls at the next hit, 0x0020. No witness is lost or duplicated, and the final `sat_count` is still 10368.
- Formula tied to 1, `N_IN`=4 -> witnesses 0..15 in order, `sat_count`=16 (needs all CNT_W bits), no wrap to 0.
- `rst` pulse mid-sweep with `wit_valid`=1 -> all outputs 0 asynchronously. A new `start` then sweeps from 0 and gives `sat_count`=10368.
- `start` pulsed while `busy` -> ignored: the sweep continues, `sat_count` is not cleared, and there is a single `done`.
